bin_frame_buffer: RTL and testbench
===================================

BIN_FRAME_BUFFER -- requirements
Module: bin_frame_buffer

Interface
REQ-001 SHALL have parameter DW, default 8, meaning width of each of the re/im parts of one bin.
REQ-002 SHALL have parameter N, default 64, meaning bins per frame; power of two, 4..4096.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port data_i, input, DW*2 bits: bin packed as {im, re}, both signed two's complement.
REQ-006 SHALL have port valid_i, input, 1 bit: data_i qualifier; there is no backpressure upstream.
REQ-007 SHALL have port sop_i, input, 1 bit: marks bin 0 of a frame; valid only together with valid_i.
REQ-008 SHALL have port sat_alarm_i, input, 1 bit: the upstream saturation alarm for the current bin.
REQ-009 SHALL have port data_o, output, DW*2 bits: stored bin, packed as {im, re}.
REQ-010 SHALL have port valid_o, output, 1 bit, and port ready_i, input, 1 bit, forming the output handshake.
REQ-011 SHALL have ports sop_o and eop_o, outputs, 1 bit each: they mark bin 0 and bin N-1 of an output frame.
REQ-012 SHALL have port bin_idx_o, output, $clog2(N) bits: index of the bin on data_o.
REQ-013 SHALL have port sat_frame_o, output, 1 bit: the output frame contained at least one saturated bin.
REQ-014 SHALL have port drop_o, output, 1 bit: one-cycle pulse when an input frame is discarded.

Function
REQ-015 SHALL hold two banks (ping-pong) of N x DW*2 bits, each with a full flag.
REQ-016 Writer SHALL have states IDLE, FILL and SKIP.
REQ-017 IDLE -> FILL on valid_i && sop_i when the target bank is not full; that bin is written at index 0.
REQ-018 IDLE -> SKIP on valid_i && sop_i when the target bank is full; drop_o SHALL pulse in that same cycle.
REQ-019 In FILL, each valid_i SHALL write the next index; valid_i without sop_i in IDLE or SKIP SHALL be ignored.
REQ-020 When index N-1 is written, the bank's full flag SHALL set on that edge, the target SHALL toggle, and the writer SHALL go to IDLE.
REQ-021 sop_i arriving during FILL SHALL restart the frame at index 0 in the same bank, with no drop_o (resync).
REQ-022 In SKIP, sop_i SHALL be re-evaluated as in IDLE, so an accepted sop takes the writer to FILL.
REQ-023 A per-bank sat flag SHALL be the OR of sat_alarm_i over the written bins; it is cleared on the bank's index-0 write.
REQ-024 Reader SHALL drain full banks in the order they were filled, bins 0..N-1.
REQ-025 valid_o SHALL first rise exactly 2 cycles after the edge that set full, when the reader is idle.
REQ-026 Throughput SHALL be one bin per cycle while ready_i=1; gaps between back-to-back frames SHALL be at most 2 cycles.
REQ-027 While valid_o && !ready_i, data_o, sop_o, eop_o, bin_idx_o and sat_frame_o SHALL stay stable.
REQ-028 A bank's full flag SHALL clear on the edge transferring its eop_o bin (valid_o && ready_i && eop_o).
REQ-029 If that clear coincides with a writer sop targeting the bank, the writer SHALL be accepted (the clear takes precedence).
REQ-030 sat_frame_o SHALL be constant for the whole output frame.

Reset
REQ-031 While rst_i=1, valid_o, sop_o, eop_o, sat_frame_o and drop_o SHALL be 0, and data_o and bin_idx_o SHALL be 0.
REQ-032 Reset SHALL clear both full flags, set writer=IDLE, target=bank 0 and reader idle; memory contents are not cleared.
REQ-033 Reset mid-frame SHALL abandon both the input and output frames; the first post-reset output SHALL be from a frame begun after reset.

Configuration
REQ-034 Macro BIN_FRAME_BUFFER_SAT_TRACK_EN defined: sat flags and sat_frame_o SHALL behave as in REQ-023 and REQ-030.
REQ-035 Macro BIN_FRAME_BUFFER_SAT_TRACK_EN undefined: the sat flag logic SHALL be absent, sat_alarm_i is ignored, and sat_frame_o SHALL be tied 0.

Verification
REQ-036 N=4, DW=8, ready_i=1; input frame re=1..4, im=-1..-4 -> data_o shows those 4 bins in order, 2 cycles after the last write, with sop_o on bin 0 and eop_o on bin 3.
REQ-037 ready_i=0 with 3 frames sent back-to-back -> frames 1 and 2 are stored, frame 3 gets drop_o=1 at its sop; after ready_i=1 exactly frames 1 and 2 emerge.
REQ-038 sop_i at index 2, then 4 bins -> only the restarted 4 bins are output and drop_o stays 0.
REQ-039 sat_alarm_i=1 on bin 2 of frame A only -> sat_frame_o=1 for all of frame A and 0 for frame B (macro defined); 0 throughout with the macro undefined.
REQ-040 ready_i toggling 1,0,0,1 during output -> no bin is lost or duplicated, and outputs stay stable while stalled.
REQ-041 rst_i pulsed at input index 2 with a frame partly output -> all outputs go to 0, and the next output frame is the first complete post-reset frame.

Source files
------------

// File: rtl/bin_frame_buffer.sv
// Ping-pong frame buffer for spectral bins: captures whole input frames into two banks and drains them in order.
// Define BIN_FRAME_BUFFER_SAT_TRACK_EN to track per-frame saturation on sat_frame_o; otherwise it is tied low.
module bin_frame_buffer #(
    parameter int DW = 8,
    parameter int N  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [2*DW-1:0]      data_i,
    input  logic                 valid_i,
    input  logic                 sop_i,
    input  logic                 sat_alarm_i,
    output logic [2*DW-1:0]      data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 sop_o,
    output logic                 eop_o,
    output logic [$clog2(N)-1:0] bin_idx_o,
    output logic                 sat_frame_o,
    output logic                 drop_o
);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [1:0] {WR_IDLE, WR_FILL, WR_SKIP} wr_state_t;

    wr_state_t       r_wr_state, w_wr_state_next;
    logic            r_wr_bank;
    logic [AW-1:0]   r_wr_idx;
    logic            w_wr_en, w_wr_last, w_drop, w_tgt_full;
    logic [AW-1:0]   w_wr_idx;
    logic [1:0]      w_full, w_clr;

    logic [2*DW-1:0] r_mem [0:2*N-1];

    logic            r_rd_active, r_rd_bank;
    logic [AW-1:0]   r_rd_idx;
    logic            r_valid, r_sop, r_eop, r_out_bank;
    logic [AW-1:0]   r_idx;
    logic [2*DW-1:0] r_data;
    logic            w_adv, w_fetch, w_xfer;

    assign w_adv   = !r_valid || ready_i;
    assign w_fetch = r_rd_active && w_adv;
    assign w_xfer  = r_valid && ready_i;
    // A bank being released this cycle already counts as free for the writer.
    assign w_tgt_full = w_full[r_wr_bank] && !w_clr[r_wr_bank];

    always_ff @(posedge clk_i) begin
        if (rst_i) r_wr_state <= WR_IDLE;
        else       r_wr_state <= w_wr_state_next;
    end

    always_comb begin
        w_wr_state_next = r_wr_state;
        case (r_wr_state)
            WR_FILL: begin
                if (valid_i && !sop_i && r_wr_idx == LAST) w_wr_state_next = WR_IDLE;
            end
            default: begin
                if (valid_i && sop_i) w_wr_state_next = w_tgt_full ? WR_SKIP : WR_FILL;
            end
        endcase
    end

    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = r_wr_idx;
        w_drop   = 1'b0;
        case (r_wr_state)
            WR_FILL: begin
                w_wr_en = valid_i;
                if (sop_i) w_wr_idx = '0;
            end
            default: begin
                if (valid_i && sop_i) begin
                    if (w_tgt_full) begin
                        w_drop = 1'b1;
                    end else begin
                        w_wr_en  = 1'b1;
                        w_wr_idx = '0;
                    end
                end
            end
        endcase
        w_wr_last = w_wr_en && (w_wr_idx == LAST);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_bank <= 1'b0;
            r_wr_idx  <= '0;
        end else if (w_wr_en) begin
            r_wr_idx <= w_wr_idx + AW'(1);
            if (w_wr_last) r_wr_bank <= ~r_wr_bank;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_en) r_mem[{r_wr_bank, w_wr_idx}] <= data_i;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic r_full;
            assign w_clr[gi]  = w_xfer && r_eop && (r_out_bank == 1'(gi));
            assign w_full[gi] = r_full;
            always_ff @(posedge clk_i) begin
                if (rst_i)                                      r_full <= 1'b0;
                else if (w_wr_last && r_wr_bank == 1'(gi))      r_full <= 1'b1;
                else if (w_clr[gi])                             r_full <= 1'b0;
            end
        end
    endgenerate

    // Reader arms one cycle after a bank fills; the registered read adds the second cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_active <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_rd_idx    <= '0;
        end else if (w_fetch) begin
            r_rd_idx <= r_rd_idx + AW'(1);
            if (r_rd_idx == LAST) begin
                r_rd_active <= 1'b0;
                r_rd_bank   <= ~r_rd_bank;
            end
        end else if (!r_rd_active && w_full[r_rd_bank]) begin
            r_rd_active <= 1'b1;
            r_rd_idx    <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data <= '0;
        end else if (w_fetch) begin
            r_data <= r_mem[{r_rd_bank, r_rd_idx}];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_idx      <= '0;
            r_out_bank <= 1'b0;
        end else if (w_fetch) begin
            r_valid    <= 1'b1;
            r_sop      <= (r_rd_idx == '0);
            r_eop      <= (r_rd_idx == LAST);
            r_idx      <= r_rd_idx;
            r_out_bank <= r_rd_bank;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

`ifdef BIN_FRAME_BUFFER_SAT_TRACK_EN
    logic [1:0] w_sat;
    logic       r_sat_o;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sat
            logic r_sat;
            assign w_sat[gi] = r_sat;
            always_ff @(posedge clk_i) begin
                if (rst_i)
                    r_sat <= 1'b0;
                else if (w_wr_en && r_wr_bank == 1'(gi))
                    r_sat <= (w_wr_idx == '0) ? sat_alarm_i : (r_sat | sat_alarm_i);
            end
        end
    endgenerate
    always_ff @(posedge clk_i) begin
        if (rst_i)        r_sat_o <= 1'b0;
        else if (w_fetch) r_sat_o <= w_sat[r_rd_bank];
    end
    assign sat_frame_o = r_sat_o && !rst_i;
`else
    logic w_unused_sat;
    assign w_unused_sat = sat_alarm_i;
    assign sat_frame_o  = 1'b0;
`endif

    // Outputs are forced low for the whole time reset is asserted, not just after its first edge.
    assign valid_o   = r_valid && !rst_i;
    assign sop_o     = r_sop && !rst_i;
    assign eop_o     = r_eop && !rst_i;
    assign bin_idx_o = rst_i ? '0 : r_idx;
    assign data_o    = rst_i ? '0 : r_data;
    assign drop_o    = w_drop && !rst_i;

endmodule

// File: tb/tb_bin_frame_buffer.sv
// Self-checking bench for bin_frame_buffer (N=4, DW=8): directed scenarios plus random traffic
// against a frame-level scoreboard of stored frames.
module tb_bin_frame_buffer;
    localparam int N  = 4;
    localparam int DW = 8;
`ifdef BIN_FRAME_BUFFER_SAT_TRACK_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, valid_i, sop_i, sat_i, ready;
    logic [2*DW-1:0] data_i;
    logic [2*DW-1:0] data_o;
    logic            valid_o, sop_o, eop_o, sat_frame_o, drop_o;
    logic [1:0]      bin_idx_o;

    bin_frame_buffer #(.DW(DW), .N(N)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data_i), .valid_i(valid_i), .sop_i(sop_i),
        .sat_alarm_i(sat_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready),
        .sop_o(sop_o), .eop_o(eop_o), .bin_idx_o(bin_idx_o), .sat_frame_o(sat_frame_o),
        .drop_o(drop_o)
    );

    int errors = 0;
    int checks = 0;

    // Scoreboard: completed frames awaiting output, and the frame being collected.
    logic [15:0] pend_bins[$];
    bit          pend_sat[$];
    int          out_k = 0;
    logic [15:0] part[$];
    bit          part_sat = 1'b0;
    bit          collecting = 1'b0;

    bit          prev_stall = 1'b0;
    logic [20:0] prev_bundle;
    logic        s_valid;
    int          drops_seen = 0, eops_seen = 0, sat_bins_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mkbin(input int re);
        int im;
        im = -re;
        return {im[7:0], re[7:0]};
    endfunction

    // One clock cycle: inputs already driven; sample at negedge, update model, advance past posedge.
    task automatic step();
        bit exp_drop;
        @(negedge clk);
        s_valid = valid_o;
        if (rst) begin
            chk("rst_outputs", {9'd0, data_o, bin_idx_o, valid_o, sop_o, eop_o, sat_frame_o, drop_o}, 32'd0);
            pend_bins.delete(); pend_sat.delete(); part.delete();
            out_k = 0; collecting = 1'b0; prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", valid_o, 1);
                chk("stall_hold", {data_o, bin_idx_o, sop_o, eop_o, sat_frame_o}, prev_bundle);
            end
            if (valid_o) chk("spurious_out", pend_sat.size() != 0, 1);
            if (valid_o && ready && pend_sat.size() != 0) begin
                chk("data", data_o, pend_bins[0]);
                chk("sop", sop_o, out_k == 0);
                chk("eop", eop_o, out_k == N - 1);
                chk("bin_idx", bin_idx_o, out_k);
                chk("sat_frame", sat_frame_o, SAT_EN ? pend_sat[0] : 1'b0);
                if (eop_o) eops_seen++;
                if (sat_frame_o) sat_bins_seen++;
                void'(pend_bins.pop_front());
                out_k++;
                if (out_k == N) begin
                    void'(pend_sat.pop_front());
                    out_k = 0;
                end
            end
            exp_drop = 1'b0;
            if (valid_i && sop_i) begin
                if (collecting || pend_sat.size() < 2) begin
                    part.delete();
                    part.push_back(data_i);
                    part_sat = sat_i;
                    collecting = 1'b1;
                end else begin
                    exp_drop = 1'b1;
                end
            end else if (valid_i && collecting) begin
                part.push_back(data_i);
                part_sat = part_sat | sat_i;
            end
            if (collecting && part.size() == N) begin
                foreach (part[i]) pend_bins.push_back(part[i]);
                pend_sat.push_back(part_sat);
                part.delete();
                collecting = 1'b0;
            end
            chk("drop", drop_o, exp_drop);
            if (drop_o) drops_seen++;
            prev_stall  = valid_o && !ready;
            prev_bundle = {data_o, bin_idx_o, sop_o, eop_o, sat_frame_o};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit s, input logic [15:0] d, input bit sat);
        valid_i = v; sop_i = s; data_i = d; sat_i = sat;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic send_frame(input int base, input int sat_pos);
        for (int i = 0; i < N; i++) drive(1'b1, i == 0, mkbin(base + i), i == sat_pos);
    endtask

    initial begin
        int d0, e0, s0, g, rdy_pct;
        bit v, s;
        bit rdy_pat [10] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 1};

        rst = 1'b1; ready = 1'b1; valid_i = 1'b0; sop_i = 1'b0; sat_i = 1'b0; data_i = '0;
        #1;
        step(); step();
        rst = 1'b0;
        idle(2);

        // Single frame re=1..4, im=-1..-4; valid_o rises two cycles after the last write.
        send_frame(1, -1);
        idle(1); chk("latency_c1", s_valid, 0);
        idle(1); chk("latency_c2", s_valid, 0);
        idle(1); chk("latency_c3", s_valid, 1);
        idle(6);

        // Three back-to-back frames with the output stalled: third is dropped.
        d0 = drops_seen; e0 = eops_seen;
        ready = 1'b0;
        send_frame(10, -1); send_frame(20, -1); send_frame(30, -1);
        idle(3);
        chk("drop_count", drops_seen - d0, 1);
        ready = 1'b1;
        idle(14);
        chk("frames_after_stall", eops_seen - e0, 2);

        // Resync: sop at index 2 restarts the frame in place.
        d0 = drops_seen; e0 = eops_seen;
        drive(1, 1, mkbin(90), 0); drive(1, 0, mkbin(91), 0);
        send_frame(100, -1);
        idle(8);
        chk("resync_frames", eops_seen - e0, 1);
        chk("resync_nodrop", drops_seen - d0, 0);

        // Saturation on bin 2 of frame A only.
        s0 = sat_bins_seen; e0 = eops_seen;
        send_frame(40, 2); send_frame(50, -1);
        idle(12);
        chk("sat_bins", sat_bins_seen - s0, SAT_EN ? N : 0);
        chk("sat_frames", eops_seen - e0, 2);

        // Ready toggling while a frame drains.
        e0 = eops_seen;
        send_frame(60, -1);
        idle(1);
        for (int i = 0; i < 10; i++) begin
            ready = rdy_pat[i];
            idle(1);
        end
        ready = 1'b1;
        idle(6);
        chk("toggle_frames", eops_seen - e0, 1);

        // Reset with one frame partly output and an input frame at index 2.
        ready = 1'b0;
        send_frame(70, -1); send_frame(80, -1);
        ready = 1'b1;
        idle(5);
        drive(1, 1, mkbin(110), 0); drive(1, 0, mkbin(111), 0);
        rst = 1'b1;
        drive(1, 0, mkbin(112), 0);
        rst = 1'b0;
        drive(1, 0, mkbin(113), 0);
        idle(4);
        e0 = eops_seen;
        send_frame(120, -1);
        idle(8);
        chk("post_reset_frames", eops_seen - e0, 1);

        // Random traffic with varying back-pressure and occasional resets.
        g = 0; rdy_pct = 100;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rdy_pct = $urandom_range(20, 100);
            ready = ($urandom_range(0, 99) < rdy_pct);
            rst = ($urandom_range(0, 999) == 0);
            v = ($urandom_range(0, 3) != 0);
            s = v && (g == 0 || $urandom_range(0, 15) == 0);
            if (v) g = s ? 1 : (g + 1) % N;
            drive(v, s, 16'($urandom), $urandom_range(0, 7) == 0);
            rst = 1'b0;
        end
        ready = 1'b1;
        idle(20);
        chk("drain_lost_bins", pend_bins.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
